wb_sequencer: RTL

Writeback controller for the single-cycle core's result path.
- Drives the 3-bit result-select of the writeback result mux and the register-file write enable/address.
- Stalls the PC while a load waits on a variable-latency data-memory response.
- Sits between the main decoder and the writeback mux / register file; memory handshake is req/ready.

---
 rtl/wb_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback controller for the single-cycle core's result path.
//
// Drives the writeback result-mux select and the register-file write port. A
// load (ResultSrc=001 with a valid register write) issues a one-cycle memory
// request and then holds the PC until the data memory answers or the wait
// budget runs out.
//
// Ports:
//   i_clk          core clock, all state on the rising edge
//   i_reset        synchronous, active-high reset
//   i_instr_valid  decoded instruction present this cycle
//   i_reg_write    decoder register-write request
//   i_result_src   decoder result select (000 ALU, 001 load, 010 PC+4, 011 PCTarget, 100 ImmExt)
//   i_rd           destination register
//   i_mem_ready    data-memory read response valid
//   o_mem_req      one-cycle load request pulse
//   o_result_sel   select to the writeback result mux
//   o_rf_we        register-file write enable
//   o_rf_waddr     register-file write address
//   o_stall        hold PC / fetch
//   o_illegal_src  sticky: result select 101-111 seen with a register write
//   o_timeout_err  sticky: a load was abandoned
//   o_stall_cycles stall-cycle counter (only with WB_PERF_CNT_EN defined)
//
// Build option: define WB_PERF_CNT_EN to add the o_stall_cycles counter.

module wb_sequencer #(
  parameter int unsigned TIMEOUT = 16,  // max wait cycles before a load is abandoned (>= 2)
  parameter int unsigned CNT_W   = 5    // wait counter width, must hold TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_instr_valid,
  input  logic        i_reg_write,
  input  logic [2:0]  i_result_src,
  input  logic [4:0]  i_rd,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic [2:0]  o_result_sel,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic        o_stall,
  output logic        o_illegal_src,
  output logic        o_timeout_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles
`endif
);

  localparam logic [2:0] SrcAlu  = 3'b000;
  localparam logic [2:0] SrcLoad = 3'b001;
  localparam logic [2:0] SrcImm  = 3'b100;

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [4:0]       r_rd, w_rd_d;
  logic             r_illegal, w_illegal_d;
  logic             r_timeout, w_timeout_d;
  logic             w_wr_req;

  assign w_wr_req = i_instr_valid & i_reg_write;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_rd      <= w_rd_d;
      r_illegal <= w_illegal_d;
      r_timeout <= w_timeout_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_rd_d       = r_rd;
    w_illegal_d  = r_illegal;
    w_timeout_d  = r_timeout;
    o_mem_req    = 1'b0;
    o_result_sel = SrcAlu;
    o_rf_we      = 1'b0;
    o_rf_waddr   = 5'd0;
    o_stall      = 1'b0;

    unique case (r_state)
      StIdle: begin
        o_rf_waddr = i_rd;
        if (i_result_src == SrcLoad) begin
          o_result_sel = SrcLoad;
          if (w_wr_req) begin
            o_mem_req = 1'b1;
            o_stall   = 1'b1;
            w_rd_d    = i_rd;
            w_cnt_d   = '0;
            w_state_d = StWaitMem;
          end
        end else if (i_result_src <= SrcImm) begin
          o_result_sel = i_result_src;
          o_rf_we      = w_wr_req;
        end else if (w_wr_req) begin
          // Reserved select: mux stays on the ALU path, nothing is written.
          w_illegal_d = 1'b1;
        end
      end
      StWaitMem: begin
        // The stalled instruction is still on the decoder inputs; ignore them.
        o_result_sel = SrcLoad;
        o_rf_waddr   = r_rd;
        if (i_mem_ready) begin
          o_rf_we   = 1'b1;
          w_state_d = StIdle;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout_d = 1'b1;
          w_state_d   = StIdle;
        end else begin
          o_stall = 1'b1;
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
    endcase

    // Reset is synchronous, so the state may still read WAIT_MEM this cycle;
    // suppress any pending write or stall while it is asserted.
    if (i_reset) begin
      o_mem_req    = 1'b0;
      o_result_sel = SrcAlu;
      o_rf_we      = 1'b0;
      o_rf_waddr   = 5'd0;
      o_stall      = 1'b0;
    end
  end

  assign o_illegal_src = r_illegal;
  assign o_timeout_err = r_timeout;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
    end else if (o_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
